// File: rtl/divider_pkg.sv
// ---------------------------------------------------------------------------
// divider_pkg
// Shared definitions for the iterative 32-bit divider and the decode stage
// that feeds it: one-hot div_op encodings, FSM state encoding, iteration
// count and a magnitude helper.
// ---------------------------------------------------------------------------
package divider_pkg;

    // One-hot operation encodings carried on div_op
    localparam logic [3:0] OP_DIV_W  = 4'b0001;
    localparam logic [3:0] OP_MOD_W  = 4'b0010;
    localparam logic [3:0] OP_DIV_WU = 4'b0100;
    localparam logic [3:0] OP_MOD_WU = 4'b1000;

    localparam logic [3:0] OP_SIGNED_MASK = OP_DIV_W | OP_MOD_W;
    localparam logic [3:0] OP_MOD_MASK    = OP_MOD_W | OP_MOD_WU;

    // Restoring steps per division; the step counter is 5 bits wide
    localparam int unsigned DIV_ITERS = 32;
    localparam logic [4:0]  CNT_LAST  = 5'(DIV_ITERS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } div_state_e;

    // Magnitude of a 32-bit operand in 33 bits so that |0x80000000| is exact.
    // Unsigned operands pass through zero-extended.
    function automatic logic [32:0] abs33(input logic [31:0] v, input logic is_signed);
        if (is_signed && v[31]) begin
            abs33 = 33'd0 - {1'b1, v};
        end else begin
            abs33 = {1'b0, v};
        end
    endfunction

endpackage

// File: rtl/divider_div_step.sv
// ---------------------------------------------------------------------------
// div_step
// One radix-2 restoring division step. The caller supplies the partial
// remainder already shifted left with the next dividend bit appended.
//   i_rem   [32:0]  shifted partial remainder
//   i_dvs   [32:0]  divisor magnitude
//   o_rem   [31:0]  next partial remainder (always below the divisor)
//   o_qbit          quotient bit produced by this step
// ---------------------------------------------------------------------------
module div_step (
    input  logic [32:0] i_rem,
    input  logic [32:0] i_dvs,
    output logic [31:0] o_rem,
    output logic        o_qbit
);

    always_comb begin
        o_qbit = (i_rem >= i_dvs);
        // After a successful subtract the difference is below the divisor,
        // which never exceeds 32 bits, so the top bit is always zero.
        o_rem  = o_qbit ? 32'(i_rem - i_dvs) : i_rem[31:0];
    end

endmodule

// File: rtl/divider.sv
// ---------------------------------------------------------------------------
// divider
// Iterative 32-bit integer divider (div.w / mod.w / div.wu / mod.wu) with
// valid/ready request and result handshakes and a flush input.
//   clk, resetn           clock, async active-low reset
//   div_valid/div_ready   request handshake
//   div_src1/div_src2     dividend / divisor
//   div_op                one-hot operation (see divider_pkg)
//   div_flush             abort any in-flight operation
//   res_valid/res_ready   result handshake
//   div_res               quotient or remainder for the latched op
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | ready for a request (div_ready = 1)
// CALC  | one working-register load cycle, then 32 restoring steps
// DONE  | result presented on div_res, held until res_ready
// ---------------------------------------------------------------------------
module divider
    import divider_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        div_valid,
    output logic        div_ready,
    input  logic [31:0] div_src1,
    input  logic [31:0] div_src2,
    input  logic [3:0]  div_op,
    input  logic        div_flush,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] div_res
);

    div_state_e  r_state;
    div_state_e  w_state_nxt;

    logic [4:0]  r_cnt;
    logic        r_load;
    logic [3:0]  r_op;
    logic        r_sign1;
    logic        r_sign2;
    logic        r_dz;
    logic [31:0] r_src1;
    logic [31:0] r_abs1;
    logic [32:0] r_abs2;
    logic [31:0] r_rem;
    logic [31:0] r_quo;

    logic        w_accept;
    logic        w_in_signed;
    logic [32:0] w_shift;
    logic [31:0] w_step_rem;
    logic        w_qbit;
    logic        w_is_signed;
    logic        w_is_mod;
    logic [31:0] w_quo_fix;
    logic [31:0] w_rem_fix;
    logic [31:0] w_res_sel;

    assign w_accept    = (r_state == ST_IDLE) && div_valid && !div_flush;
    assign w_in_signed = |(div_op & OP_SIGNED_MASK);

    // Shift the next dividend bit (quotient register MSB) into the remainder
    assign w_shift = {r_rem, r_quo[31]};

    div_step u_div_step (
        .i_rem  (w_shift),
        .i_dvs  (r_abs2),
        .o_rem  (w_step_rem),
        .o_qbit (w_qbit)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_CALC;
                end
            end
            ST_CALC: begin
                if (div_flush) begin
                    w_state_nxt = ST_IDLE;
                end else if (!r_load && (r_cnt == CNT_LAST)) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (div_flush || res_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        div_ready = 1'b0;
        res_valid = 1'b0;
        div_res   = 32'd0;
        case (r_state)
            ST_IDLE: div_ready = 1'b1;
            ST_DONE: begin
                res_valid = 1'b1;
                div_res   = w_res_sel;
            end
            default: ;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt   <= 5'd0;
            r_load  <= 1'b0;
            r_op    <= 4'd0;
            r_sign1 <= 1'b0;
            r_sign2 <= 1'b0;
            r_dz    <= 1'b0;
            r_src1  <= 32'd0;
            r_abs1  <= 32'd0;
            r_abs2  <= 33'd0;
            r_rem   <= 32'd0;
            r_quo   <= 32'd0;
        end else if (div_flush) begin
            r_cnt  <= 5'd0;
            r_load <= 1'b0;
        end else if (w_accept) begin
            r_op    <= div_op;
            r_sign1 <= w_in_signed & div_src1[31];
            r_sign2 <= w_in_signed & div_src2[31];
            r_dz    <= (div_src2 == 32'd0);
            r_src1  <= div_src1;
            // A signed dividend magnitude is at most 2^31, so 32 bits suffice
            r_abs1  <= 32'(abs33(div_src1, w_in_signed));
            r_abs2  <= abs33(div_src2, w_in_signed);
            r_cnt   <= 5'd0;
            r_load  <= 1'b1;
        end else if (r_state == ST_CALC) begin
            if (r_load) begin
                // Working registers are loaded from the latched magnitudes so
                // the step logic never sees the live request inputs.
                r_rem  <= 32'd0;
                r_quo  <= r_abs1;
                r_load <= 1'b0;
            end else begin
                r_rem <= w_step_rem;
                r_quo <= {r_quo[30:0], w_qbit};
                r_cnt <= r_cnt + 5'd1;
            end
        end
    end

    // ---------------- result fix-up (registered values only) ----------------
    always_comb begin
        w_is_signed = |(r_op & OP_SIGNED_MASK);
        w_is_mod    = |(r_op & OP_MOD_MASK);
        w_quo_fix   = (w_is_signed && (r_sign1 ^ r_sign2)) ? (32'd0 - r_quo) : r_quo;
        w_rem_fix   = (w_is_signed && r_sign1) ? (32'd0 - r_rem) : r_rem;
        if (r_dz) begin
            // Divide by zero: all-ones quotient, dividend returned untouched
            w_quo_fix = 32'hFFFF_FFFF;
            w_rem_fix = r_src1;
        end
        w_res_sel = w_is_mod ? w_rem_fix : w_quo_fix;
    end

endmodule

// File: doc/divider.md
DIVIDER -- requirements
Module: divider

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-002 SHALL have port resetn, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port div_valid, input, 1 bit: request valid.
REQ-004 SHALL have port div_ready, output, 1 bit: block can accept a request.
REQ-005 SHALL have port div_src1, input, 32 bits: dividend.
REQ-006 SHALL have port div_src2, input, 32 bits: divisor.
REQ-007 SHALL have port div_op, input, 4 bits, one-hot: 0001 div.w, 0010 mod.w, 0100 div.wu, 1000 mod.wu.
REQ-008 SHALL have port div_flush, input, 1 bit: abort any in-flight operation.
REQ-009 SHALL have port res_valid, output, 1 bit: result valid.
REQ-010 SHALL have port res_ready, input, 1 bit: consumer accepts result.
REQ-011 SHALL have port div_res, output, 32 bits: quotient or remainder selected by the latched op.

Function
REQ-012 SHALL implement FSM states IDLE, CALC and DONE.
REQ-013 SHALL assert div_ready only in IDLE and SHALL accept a request on the cycle div_valid && div_ready && !div_flush.
REQ-014 SHALL, on acceptance, latch op, operand signs, divide-by-zero flag and absolute values (|src| for .w ops, raw for .wu ops), then go to CALC.
REQ-015 SHALL perform one radix-2 restoring step per CALC cycle for exactly 32 cycles, tracked by a 5-bit counter; the 32nd step SHALL transition to DONE.
REQ-016 SHALL assert res_valid only in DONE, first on the 33rd rising edge after the accepting edge.
REQ-017 SHALL hold res_valid and div_res stable in DONE while res_ready is low, and return to IDLE on the edge where res_valid && res_ready.
REQ-018 Signed ops SHALL give quotient sign = sign1 XOR sign2 and remainder sign = sign1; magnitudes use 33-bit internal widths so |0x80000000| is exact.
REQ-019 SHALL give 0x80000000 / 0xFFFFFFFF (div.w) = 0x80000000, and mod.w of the same operands = 0.
REQ-020 SHALL give, on divisor zero, quotient 0xFFFFFFFF and remainder = div_src1 unmodified, for all four ops, with normal 33-cycle latency.
REQ-021 SHALL, when div_flush is high, go to IDLE on the next edge from any state, drop the result and not assert res_valid; div_flush has priority over acceptance and over res_ready.
REQ-022 SHALL apply sign fix-up and quotient/remainder selection to registered values, so div_res is combinational only from internal registers and holds no path from div_src*.
REQ-023 SHALL ignore div_valid outside IDLE; the requester must hold its request until div_ready.

Reset
REQ-024 SHALL, while resetn is low, force state IDLE, counter 0, and all datapath registers 0.
REQ-025 SHALL drive div_ready = 1, res_valid = 0 and div_res = 0 during reset; reset mid-CALC discards the operation with no res_valid.

Structure
REQ-026 SHALL place the div_op one-hot encodings, the FSM state encoding, and the iteration count constant (32) in a shared package, shared with the decode stage.
REQ-027 SHALL instantiate a sub-module div_step: one restoring step, 33-bit partial remainder and divisor in, next partial remainder and quotient bit out.

Verification
REQ-028 div.w 100 / 7 -> res_valid 33 cycles after accept, div_res = 14; mod.w of the same -> 2.
REQ-029 mod.w 0xFFFFFFF9 (-7) by 2 -> 0xFFFFFFFF (-1); div.w -> 0xFFFFFFFD (-3).
REQ-030 div.wu 0xFFFFFFFF / 2 -> 0x7FFFFFFF; mod.wu -> 1; div.w 0x80000000 / 0xFFFFFFFF -> 0x80000000.
REQ-031 div.w 0xFFFFFFF0 / 0 -> 0xFFFFFFFF; mod.w -> 0xFFFFFFF0.
REQ-032 Flush at CALC cycle 10 -> IDLE next edge, res_valid never rises; the next request (81 / 9) -> 9 with full latency.
REQ-033 Hold res_ready low 5 cycles in DONE -> res_valid and div_res stable, div_ready = 0; raise res_ready -> IDLE next edge; resetn pulse mid-CALC -> outputs at reset values.
